// File: rtl/time_display_driver.sv
// time_display_driver
// Drives a 6-digit multiplexed, common-anode 7-segment display from the
// binary time produced by the clock counter block. A prescaler produces a
// digit-scan tick, a second divider produces the blink phase, and the time
// is snapshotted once per scan frame so a frame never mixes two readings.
// Out-of-range fields show dashes, and the field being set blinks.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-low reset
//   sec_in     seconds, binary (0-59)
//   min_in     minutes, binary (0-59)
//   hour_in    hours, binary (0-23)
//   mode       0 = normal, 1 = setting
//   set_pos    one-hot field being set: 100 hour, 010 minute, 001 second
//   seg_out    segments {g,f,e,d,c,b,a}, active-low
//   dp_out     decimal point, active-low
//   digit_sel  one-hot active-low digit enable, bit0 = seconds units
module time_display_driver #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] sec_in,
  input  logic [5:0] min_in,
  input  logic [4:0] hour_in,
  input  logic       mode,
  input  logic [2:0] set_pos,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic [5:0] digit_sel
);

  localparam int PW = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [PW-1:0] presc;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          scan_tick;
  logic          upd;
  logic [2:0]    digit_idx;

  logic [5:0]    snap_sec;
  logic [5:0]    snap_min;
  logic [4:0]    snap_hour;
  logic          snap_mode;
  logic [2:0]    snap_pos;

  assign scan_tick = (presc == PW'(SCAN_DIV - 1));

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  // Stage 1: timebase, digit index and frame snapshot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc       <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      digit_idx   <= 3'd5;
      upd         <= 1'b0;
      snap_sec    <= '0;
      snap_min    <= '0;
      snap_hour   <= '0;
      snap_mode   <= 1'b0;
      snap_pos    <= '0;
    end else begin
      presc <= scan_tick ? '0 : presc + 1'b1;
      upd   <= scan_tick;

      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      if (scan_tick) begin
        if (digit_idx == 3'd5) begin
          digit_idx <= 3'd0;
          snap_sec  <= sec_in;
          snap_min  <= min_in;
          snap_hour <= hour_in;
          snap_mode <= mode;
          snap_pos  <= set_pos;
        end else begin
          digit_idx <= digit_idx + 3'd1;
        end
      end
    end
  end

  logic [5:0] fld_val;
  logic       fld_ok;
  logic [2:0] fld_pos;
  logic [3:0] digit;
  logic [6:0] seg_nxt;
  logic       dp_nxt;
  logic [5:0] sel_nxt;

  always_comb begin
    fld_val = snap_sec;
    fld_ok  = (snap_sec <= 6'd59);
    fld_pos = 3'b001;
    case (digit_idx)
      3'd2, 3'd3: begin
        fld_val = snap_min;
        fld_ok  = (snap_min <= 6'd59);
        fld_pos = 3'b010;
      end
      3'd4, 3'd5: begin
        fld_val = {1'b0, snap_hour};
        fld_ok  = (snap_hour <= 5'd23);
        fld_pos = 3'b100;
      end
      default: ;
    endcase

    // Even index is the units digit of its field, odd index the tens.
    digit = digit_idx[0] ? 4'(fld_val / 6'd10) : 4'(fld_val % 6'd10);

    if (snap_mode && blink_phase && (snap_pos == fld_pos))
      seg_nxt = 7'b1111111;
    else if (!fld_ok)
      seg_nxt = 7'b0111111;
    else
      seg_nxt = seg_code(digit);

    dp_nxt  = 1'b1;
    if (digit_idx == 3'd2 || digit_idx == 3'd4)
      dp_nxt = snap_mode ? 1'b0 : blink_phase;

    sel_nxt = ~(6'b000001 << digit_idx);
  end

  // Stage 2: outputs change only one edge after a scan tick, so each slot is
  // rendered from a settled index/snapshot and blink cannot change mid-slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      seg_out   <= 7'b1111111;
      dp_out    <= 1'b1;
      digit_sel <= 6'b111111;
    end else if (upd) begin
      seg_out   <= seg_nxt;
      dp_out    <= dp_nxt;
      digit_sel <= sel_nxt;
    end
  end

endmodule

// File: tb/tb_time_display_driver.sv
module tb_time_display_driver;

  localparam int SD_ = 4;
  localparam int BD_ = 16;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SD = 7'b0111111, SB = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] sec_in, min_in;
  logic [4:0] hour_in;
  logic       mode;
  logic [2:0] set_pos;
  logic [6:0] seg_out;
  logic       dp_out;
  logic [5:0] digit_sel;

  time_display_driver #(.SCAN_DIV(SD_), .BLINK_DIV(BD_)) dut (
    .clk(clk), .reset(reset), .sec_in(sec_in), .min_in(min_in),
    .hour_in(hour_in), .mode(mode), .set_pos(set_pos),
    .seg_out(seg_out), .dp_out(dp_out), .digit_sel(digit_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      hour;
    logic [5:0]      mn;
    logic [5:0]      sec;
    logic            md;
    logic [2:0]      pos;
    logic [5:0][6:0] seg;    // expected unblanked code, index = digit
    logic [5:0]      blank;  // digits blanked while blink phase is 1
  } vec_t;

  localparam int NV = 10;
  vec_t vt [NV];

  function automatic vec_t mk(input int h, input int m, input int s,
                              input logic md, input logic [2:0] pos,
                              input logic [41:0] segs, input logic [5:0] blank);
    vec_t v;
    v.hour = 5'(h); v.mn = 6'(m); v.sec = 6'(s);
    v.md = md; v.pos = pos; v.seg = segs; v.blank = blank;
    return v;
  endfunction

  int pass_cnt = 0;
  int total = 0;
  int cur_vec = 0;
  int snap_vec = 0;
  int cyc = 0;
  logic [13:0] sb [$];
  logic [13:0] cur_exp;
  bit chk_en = 0;

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s cyc=%0d got sel/dp/seg=%b/%b/%b want %b/%b/%b", name, cyc,
                  act[13:8], act[7], act[6:0], exp[13:8], exp[7], exp[6:0]);
  endtask

  task automatic apply(input int i);
    cur_vec = i;
    hour_in = vt[i].hour; min_in = vt[i].mn; sec_in = vt[i].sec;
    mode = vt[i].md; set_pos = vt[i].pos;
  endtask

  // Reference timing: edges counted since reset release. Snapshot at edge
  // 4+24k, output updates at edge 5+4n, blink phase = floor(edge/16) mod 2.
  initial begin
    int n, idx, ph;
    logic [6:0] s;
    logic d;
    forever begin
      @(posedge clk);
      if (!reset) begin
        sb.delete();
        sb.push_back({6'h3F, 1'b1, SB});
        cyc = 0;
      end else begin
        cyc++;
        if (cyc >= 4 && (cyc - 4) % 24 == 0) snap_vec = cur_vec;
        if (cyc >= 5 && (cyc - 5) % 4 == 0) begin
          n   = (cyc - 5) / 4;
          idx = n % 6;
          ph  = ((cyc - 1) / 16) % 2;
          s   = (ph == 1 && vt[snap_vec].blank[idx]) ? SB : vt[snap_vec].seg[idx];
          d   = 1'b1;
          if (idx == 2 || idx == 4) d = vt[snap_vec].md ? 1'b0 : ph[0];
          sb.push_back({~(6'b000001 << idx), d, s});
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        cur_exp = sb.pop_front();
        chk_en  = 1;
      end
      if (chk_en) check("slot_out", {digit_sel, dp_out, seg_out}, cur_exp);
    end
  end

  initial begin
    int first;
    vt[0] = mk(12, 34, 56, 0, 3'b000, {S1, S2, S3, S4, S5, S6}, 6'b000000);
    vt[1] = mk(12, 34, 57, 0, 3'b000, {S1, S2, S3, S4, S5, S7}, 6'b000000);
    vt[2] = mk(12, 34, 57, 1, 3'b010, {S1, S2, S3, S4, S5, S7}, 6'b001100);
    vt[3] = mk(12, 34, 57, 1, 3'b011, {S1, S2, S3, S4, S5, S7}, 6'b000000);
    vt[4] = mk(25, 60, 56, 0, 3'b000, {SD, SD, SD, SD, S5, S6}, 6'b000000);
    vt[5] = mk(23, 59,  7, 1, 3'b100, {S2, S3, S5, S9, S0, S7}, 6'b110000);
    vt[6] = mk( 0,  0,  0, 1, 3'b001, {S0, S0, S0, S0, S0, S0}, 6'b000011);
    vt[7] = mk(24,  0, 59, 0, 3'b001, {SD, SD, S0, S0, S5, S9}, 6'b000000);
    vt[8] = mk( 9,  5, 60, 1, 3'b000, {S0, S9, S0, S5, SD, SD}, 6'b000000);
    vt[9] = mk(18, 47, 38, 1, 3'b111, {S1, S8, S4, S7, S3, S8}, 6'b000000);

    apply(0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dark", {digit_sel, dp_out, seg_out}, {6'h3F, 1'b1, SB});
    reset = 1'b1;

    // Inputs change while digit 3 is displayed, so each new vector first
    // appears one frame later.
    repeat (18) @(negedge clk);
    for (int i = 1; i < NV; i++) begin
      apply(i);
      repeat (48) @(negedge clk);
    end

    // Mid-frame reset for one cycle, then the scan must restart cleanly.
    repeat (9) @(negedge clk);
    reset = 1'b0;
    apply(0);
    @(negedge clk);
    check("midframe_reset", {digit_sel, dp_out, seg_out}, {6'h3F, 1'b1, SB});
    reset = 1'b1;
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (digit_sel !== 6'h3F) begin
        first = k;
        break;
      end
    end
    check("first_update_edge", 14'(first), 14'd5);
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
